// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM and IF/ID register.
// A response that arrives while decode is stalled is parked in a hold buffer until the stall clears.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pcf, pcf_nxt;
  logic [XLEN-1:0]   pcf_plus4;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   hold_buf, hold_nxt;
  logic [XLEN-1:0]   fetch_word;
  logic              fetch_done;
  logic              unused_target_lsb;

  // Instructions are word aligned, so the low target bits carry no information.
  assign target            = {PCTargetE[XLEN-1:2], 2'b00};
  assign unused_target_lsb = ^PCTargetE[1:0];
  assign pcf_plus4         = pcf + XLEN'(4);
  assign imem_addr         = pcf;

  // Fetch FSM state, PC and hold buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ISSUE;
      pcf      <= {RESET_PC[XLEN-1:2], 2'b00};
      hold_buf <= '0;
    end else begin
      state    <= state_nxt;
      pcf      <= pcf_nxt;
      hold_buf <= hold_nxt;
    end
  end

  // Next state, next PC and request strobe; a redirect always beats a stall.
  always_comb begin
    state_nxt  = state;
    pcf_nxt    = pcf;
    hold_nxt   = hold_buf;
    fetch_done = 1'b0;
    fetch_word = hold_buf;
    imem_req   = 1'b0;

    case (state)
      ISSUE: begin
        imem_req = !PCSrcE;
        if (PCSrcE) begin
          pcf_nxt = target;
        end else begin
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        if (PCSrcE) begin
          pcf_nxt   = target;
          state_nxt = imem_valid ? ISSUE : DISCARD;
        end else if (imem_valid) begin
          if (StallD) begin
            hold_nxt  = imem_rdata;
            state_nxt = HOLD;
          end else begin
            fetch_done = 1'b1;
            fetch_word = imem_rdata;
            pcf_nxt    = pcf_plus4;
            state_nxt  = ISSUE;
          end
        end
      end

      HOLD: begin
        if (PCSrcE) begin
          hold_nxt  = '0;
          pcf_nxt   = target;
          state_nxt = ISSUE;
        end else if (!StallD) begin
          fetch_done = 1'b1;
          pcf_nxt    = pcf_plus4;
          state_nxt  = ISSUE;
        end
      end

      DISCARD: begin
        if (PCSrcE) begin
          pcf_nxt = target;
        end
        if (imem_valid) begin
          state_nxt = ISSUE;
        end
      end

      default: begin
        state_nxt = ISSUE;
      end
    endcase

    if (rst) begin
      imem_req = 1'b0;
    end
  end

  // IF/ID register: flush, then stall, then a completed fetch, otherwise a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (fetch_done) begin
      InstrD   <= fetch_word;
      PCD      <= pcf;
      PCPlus4D <= pcf_plus4;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed timeline driving stall/flush/redirect/reset
// against a latency-programmable instruction memory, plus a wrap-around reset-PC instance.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  logic        w_req, w_valid, w_vd, w_pend;
  logic [31:0] w_addr, w_instr, w_pcd, w_pcplus4;

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 1;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } id_t;

  logic [31:0] exp_addr[$];
  id_t         exp_id[$];

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .StallD(1'b0), .FlushD(1'b0),
    .PCSrcE(1'b0), .PCTargetE(32'h0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_valid(w_valid), .imem_rdata(32'h0000_0093),
    .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_pcplus4), .ValidD(w_vd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_000C: return 32'hDEAD_BEEF;
      default:       return {a[19:0], 12'h013};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction memory for the main instance: answers each request after lat cycles.
  initial begin
    int          cnt;
    logic [31:0] raddr;
    cnt = 0;
    raddr = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(raddr);
        end
      end
      @(negedge clk);
      if (rst) cnt = 0;
      else if (imem_req) begin
        cnt   = lat;
        raddr = imem_addr;
      end
    end
  end

  // One-cycle memory for the wrap instance.
  initial begin
    w_valid = 1'b0;
    w_pend  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      w_valid = w_pend;
      w_pend  = 1'b0;
      @(negedge clk);
      if (!rst && w_req) w_pend = 1'b1;
    end
  end

  // Monitor: pops an expectation for every request and every new IF/ID entry.
  initial begin
    logic        prev_v;
    logic [31:0] prev_i, prev_p;
    id_t         e;
    prev_v = 1'b0;
    prev_i = '0;
    prev_p = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req === 1'b1) begin
          if (exp_addr.size() == 0) begin
            n_chk++;
            $display("FAIL req_unexpected: got addr %h, expected no request", imem_addr);
          end else begin
            chk("imem_addr", imem_addr, exp_addr.pop_front());
          end
        end
        if (ValidD === 1'b1 && (!prev_v || InstrD !== prev_i || PCD !== prev_p)) begin
          if (exp_id.size() == 0) begin
            n_chk++;
            $display("FAIL id_unexpected: got instr %h pc %h, expected no entry", InstrD, PCD);
          end else begin
            e = exp_id.pop_front();
            chk("InstrD", InstrD, e.instr);
            chk("PCD", PCD, e.pc);
            chk("PCPlus4D", PCPlus4D, e.pc + 32'd4);
          end
        end
      end
      prev_v = (ValidD === 1'b1);
      prev_i = InstrD;
      prev_p = PCD;
    end
  end

  // Directed timeline; cycle n starts 1 time unit after the n-th edge past reset release.
  initial begin
    rst = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;

    foreach (exp_addr[i]) exp_addr.delete(i);
    exp_addr.push_back(32'h000); exp_addr.push_back(32'h004);
    exp_addr.push_back(32'h008); exp_addr.push_back(32'h00C);
    exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
    exp_addr.push_back(32'h200); exp_addr.push_back(32'h204);
    exp_addr.push_back(32'h208); exp_addr.push_back(32'h20C);
    exp_addr.push_back(32'h000); exp_addr.push_back(32'h004);
    exp_id.push_back('{32'h0050_0093, 32'h000});
    exp_id.push_back('{32'h00A0_0113, 32'h004});
    exp_id.push_back('{32'h0000_8013, 32'h008});
    exp_id.push_back('{32'h0010_0013, 32'h100});
    exp_id.push_back('{32'h0020_0013, 32'h200});
    exp_id.push_back('{32'h0020_8013, 32'h208});
    exp_id.push_back('{32'h0050_0093, 32'h000});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'h0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcplus4", PCPlus4D, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;

    for (int n = 0; n < 30; n++) begin
      rst    = (n == 25 || n == 26);
      StallD = (n >= 4 && n <= 6);
      FlushD = (n == 15 || n == 19);
      PCSrcE = (n == 9 || n == 15 || n == 23 || n == 24 || n == 25 || n == 26);
      case (n)
        9:       PCTargetE = 32'h0000_0100;
        15:      PCTargetE = 32'h0000_0203;
        23:      PCTargetE = 32'h0000_0300;
        24:      PCTargetE = 32'h0000_0400;
        default: PCTargetE = 32'h0000_0500;
      endcase
      lat = (n == 8) ? 3 : (n == 22) ? 4 : 1;

      @(negedge clk);
      case (n)
        0: begin
          chk("wrap_first_req", {31'b0, w_req}, 32'h1);
          chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        end
        2: begin
          chk("first_valid", {31'b0, ValidD}, 32'h1);
          chk("wrap_pcplus4", w_pcplus4, 32'h0);
          chk("wrap_pcd", w_pcd, 32'hFFFF_FFFC);
          chk("wrap_valid", {31'b0, w_vd}, 32'h1);
          chk("wrap_next_addr", w_addr, 32'h0);
        end
        3: begin
          chk("bubble_valid", {31'b0, ValidD}, 32'h0);
          chk("bubble_pcd_held", PCD, 32'h0);
        end
        6, 7: begin
          chk("hold_no_req", {31'b0, imem_req}, 32'h0);
          chk("hold_idid_valid", {31'b0, ValidD}, 32'h1);
          chk("hold_idid_instr", InstrD, 32'h00A0_0113);
        end
        8: begin
          chk("unstall_instr", InstrD, 32'h0000_8013);
          chk("unstall_pc_adv", imem_addr, 32'h0000_000C);
        end
        10: begin
          chk("discard_no_req", {31'b0, imem_req}, 32'h0);
          chk("discard_pcf", imem_addr, 32'h0000_0100);
        end
        11, 12: begin
          chk("stale_word_dropped", InstrD, NOP);
          chk("stale_valid", {31'b0, ValidD}, 32'h0);
        end
        16: begin
          chk("flush_redir_valid", {31'b0, ValidD}, 32'h0);
          chk("flush_redir_instr", InstrD, NOP);
          chk("flush_redir_pcd", PCD, 32'h0);
          chk("flush_redir_pcplus4", PCPlus4D, 32'h0);
          chk("flush_redir_addr", imem_addr, 32'h0000_0200);
        end
        20: begin
          chk("flush_done_valid", {31'b0, ValidD}, 32'h0);
          chk("flush_done_pcd", PCD, 32'h0);
          chk("flush_done_addr", imem_addr, 32'h0000_0208);
        end
        25: begin
          chk("discard_redir_again", imem_addr, 32'h0000_0400);
          chk("rst_req_discard", {31'b0, imem_req}, 32'h0);
        end
        26: begin
          chk("rst_req_issue", {31'b0, imem_req}, 32'h0);
          chk("rst_pcf", imem_addr, 32'h0);
          chk("rst_valid_2", {31'b0, ValidD}, 32'h0);
          chk("rst_instr_2", InstrD, NOP);
        end
        27: begin
          chk("reissue_req", {31'b0, imem_req}, 32'h1);
          chk("reissue_addr", imem_addr, 32'h0);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    chk("addr_q_drained", 32'(exp_addr.size()), 32'h0);
    chk("id_q_drained", 32'(exp_id.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
